// File: rtl/calc_entry_ctrl.sv
// calc_entry_ctrl: keypad-entry sequencer for the calculator.
// Builds two decimal operands from validated key codes, latches the
// operator, pulses the ALU start, waits for the result (with timeout) and
// selects the value shown on the display.
//
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   key_code, key_valid 0-9 digit, 10-13 operator, 14 equals, 15 clear
//   alu_done            one-cycle result-valid pulse from the ALU
//   alu_result/neg/err  unsigned magnitude, sign and fault from the ALU
//   operand_a/b, op_sel operands and operator presented to the ALU
//   calc_start          one-cycle ALU start pulse
//   disp_value/neg      display magnitude and sign
//   err, busy           error indicator, high while waiting on the ALU
module calc_entry_ctrl #(
  parameter int unsigned MAX_DIGITS = 3,
  parameter int unsigned WIDTH      = 10,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         key_code,
  input  logic               key_valid,
  input  logic               alu_done,
  input  logic [2*WIDTH-1:0] alu_result,
  input  logic               alu_neg,
  input  logic               alu_err,
  output logic [WIDTH-1:0]   operand_a,
  output logic [WIDTH-1:0]   operand_b,
  output logic [1:0]         op_sel,
  output logic               calc_start,
  output logic [2*WIDTH-1:0] disp_value,
  output logic               disp_neg,
  output logic               err,
  output logic               busy
);

  localparam int unsigned CW = $clog2(MAX_DIGITS + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned RW = 2 * WIDTH;
  localparam logic [RW-1:0] MAX_VAL = RW'(10 ** MAX_DIGITS - 1);

  // S_START is the single cycle between the equals key and WAIT in which
  // calc_start is asserted.
  typedef enum logic [2:0] {
    S_ENTER_A,
    S_ENTER_B,
    S_START,
    S_WAIT,
    S_SHOW,
    S_ERROR
  } state_t;

  state_t          state, state_n;
  logic [WIDTH-1:0] a_q, a_n, b_q, b_n;
  logic [1:0]      op_q, op_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic [TW-1:0]   tmr_q, tmr_n;
  logic [RW-1:0]   res_q, res_n;
  logic            neg_q, neg_n;

  logic             is_digit, is_op, is_eq, is_clr;
  logic [1:0]       key_op;
  logic [WIDTH-1:0] a_dig, b_dig;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_ENTER_A;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      cnt_q <= '0;
      tmr_q <= '0;
      res_q <= '0;
      neg_q <= 1'b0;
    end else begin
      state <= state_n;
      a_q   <= a_n;
      b_q   <= b_n;
      op_q  <= op_n;
      cnt_q <= cnt_n;
      tmr_q <= tmr_n;
      res_q <= res_n;
      neg_q <= neg_n;
    end
  end

  always_comb begin
    is_digit = key_valid && (key_code < 4'd10);
    is_op    = key_valid && (key_code >= 4'd10) && (key_code <= 4'd13);
    is_eq    = key_valid && (key_code == 4'd14);
    is_clr   = key_valid && (key_code == 4'd15);
    key_op   = 2'(key_code - 4'd10);
    // acc*10 + d evaluated at WIDTH+4 bits, then truncated back to WIDTH
    a_dig = WIDTH'({4'b0000, a_q} * (WIDTH + 4)'(10) + (WIDTH + 4)'(key_code));
    b_dig = WIDTH'({4'b0000, b_q} * (WIDTH + 4)'(10) + (WIDTH + 4)'(key_code));

    state_n = state;
    a_n     = a_q;
    b_n     = b_q;
    op_n    = op_q;
    cnt_n   = cnt_q;
    tmr_n   = tmr_q;
    res_n   = res_q;
    neg_n   = neg_q;

    case (state)
      S_ENTER_A: begin
        if (is_digit && (cnt_q < CW'(MAX_DIGITS))) begin
          a_n   = a_dig;
          cnt_n = cnt_q + CW'(1);
        end else if (is_op) begin
          op_n    = key_op;
          b_n     = '0;
          cnt_n   = '0;
          state_n = S_ENTER_B;
        end
      end
      S_ENTER_B: begin
        if (is_digit && (cnt_q < CW'(MAX_DIGITS))) begin
          b_n   = b_dig;
          cnt_n = cnt_q + CW'(1);
        end else if (is_op && (cnt_q == '0)) begin
          op_n = key_op;
        end else if (is_eq) begin
          state_n = S_START;
        end
      end
      S_START: begin
        tmr_n   = '0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        // A completing ALU beats both the timeout and any non-clear key.
        if (alu_done) begin
          res_n   = alu_result;
          neg_n   = alu_neg;
          state_n = alu_err ? S_ERROR : S_SHOW;
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          state_n = S_ERROR;
        end else begin
          tmr_n = tmr_q + TW'(1);
        end
      end
      S_SHOW: begin
        if (is_digit) begin
          a_n     = WIDTH'(key_code);
          b_n     = '0;
          cnt_n   = CW'(1);
          state_n = S_ENTER_A;
        end else if (is_op && !neg_q && (res_q <= MAX_VAL)) begin
          a_n     = WIDTH'(res_q);
          b_n     = '0;
          op_n    = key_op;
          cnt_n   = '0;
          state_n = S_ENTER_B;
        end
      end
      default: ;
    endcase

    if (is_clr) begin
      state_n = S_ENTER_A;
      a_n     = '0;
      b_n     = '0;
      op_n    = '0;
      cnt_n   = '0;
      tmr_n   = '0;
      res_n   = '0;
      neg_n   = 1'b0;
    end
  end

  always_comb begin
    operand_a  = a_q;
    operand_b  = b_q;
    op_sel     = op_q;
    calc_start = (state == S_START);
    busy       = (state == S_WAIT);
    err        = (state == S_ERROR);
    disp_neg   = (state == S_SHOW) && neg_q;
    disp_value = '0;
    case (state)
      S_ENTER_A:       disp_value = RW'(a_q);
      S_ENTER_B:       disp_value = (cnt_q != '0) ? RW'(b_q) : RW'(a_q);
      S_START, S_WAIT: disp_value = RW'(b_q);
      S_SHOW:          disp_value = res_q;
      default:         disp_value = '0;
    endcase
  end

endmodule

// File: tb/tb_calc_entry_ctrl.sv
module tb_calc_entry_ctrl;

  localparam int MAXD = 3;
  localparam int W    = 10;
  localparam int TO   = 64;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [3:0]     key_code = '0;
  logic           key_valid = 1'b0;
  logic           alu_done = 1'b0;
  logic [2*W-1:0] alu_result = '0;
  logic           alu_neg = 1'b0;
  logic           alu_err = 1'b0;
  logic [W-1:0]   operand_a, operand_b;
  logic [1:0]     op_sel;
  logic           calc_start;
  logic [2*W-1:0] disp_value;
  logic           disp_neg, err, busy;

  calc_entry_ctrl #(.MAX_DIGITS(MAXD), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .key_code(key_code), .key_valid(key_valid),
    .alu_done(alu_done), .alu_result(alu_result), .alu_neg(alu_neg),
    .alu_err(alu_err), .operand_a(operand_a), .operand_b(operand_b),
    .op_sel(op_sel), .calc_start(calc_start), .disp_value(disp_value),
    .disp_neg(disp_neg), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: calculator phases, per-operand digit counts and the
  // number of cycles spent waiting since the ALU was started.
  typedef enum {P_A, P_B, P_GO, P_WAIT, P_SHOW, P_ERR} phase_t;
  phase_t ph   = P_A;
  longint ma   = 0, mb = 0, mres = 0;
  int     mop  = 0, na = 0, nb = 0, age = 0;
  bit     mneg = 1'b0;
  longint lim  = 10 ** MAXD - 1;

  task automatic m_clear();
    ph = P_A; ma = 0; mb = 0; mop = 0; na = 0; nb = 0; age = 0;
    mres = 0; mneg = 1'b0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) m_clear();
    else if (key_valid && key_code == 15) m_clear();
    else begin
      case (ph)
        P_A: if (key_valid) begin
          if (key_code < 10) begin
            if (na < MAXD) begin ma = ma * 10 + key_code; na++; end
          end else if (key_code <= 13) begin
            mop = key_code - 10; mb = 0; nb = 0; ph = P_B;
          end
        end
        P_B: if (key_valid) begin
          if (key_code < 10) begin
            if (nb < MAXD) begin mb = mb * 10 + key_code; nb++; end
          end else if (key_code <= 13) begin
            if (nb == 0) mop = key_code - 10;
          end else if (key_code == 14) ph = P_GO;
        end
        P_GO: begin ph = P_WAIT; age = 0; end
        P_WAIT: begin
          if (alu_done) begin
            mres = alu_result; mneg = alu_neg;
            ph = alu_err ? P_ERR : P_SHOW;
          end else begin
            age++;
            if (age == TO) ph = P_ERR;
          end
        end
        P_SHOW: if (key_valid) begin
          if (key_code < 10) begin
            ma = key_code; na = 1; mb = 0; nb = 0; ph = P_A;
          end else if (key_code <= 13 && !mneg && mres <= lim) begin
            ma = mres; mb = 0; nb = 0; mop = key_code - 10; ph = P_B;
          end
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    longint ed;
    case (ph)
      P_A:          ed = ma;
      P_B:          ed = (nb > 0) ? mb : ma;
      P_GO, P_WAIT: ed = mb;
      P_SHOW:       ed = mres;
      default:      ed = 0;
    endcase
    chk("operand_a", operand_a, ma);
    chk("operand_b", operand_b, mb);
    chk("op_sel", op_sel, mop);
    chk("calc_start", calc_start, ph == P_GO);
    chk("busy", busy, ph == P_WAIT);
    chk("err", err, ph == P_ERR);
    chk("disp_value", disp_value, ed);
    chk("disp_neg", disp_neg, (ph == P_SHOW) && mneg);
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic key(input int k);
    step();
    key_code  = 4'(k);
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
  endtask

  task automatic done(input longint r, input bit n, input bit e);
    step();
    alu_result = (2*W)'(r);
    alu_neg    = n;
    alu_err    = e;
    alu_done   = 1'b1;
    step();
    alu_done = 1'b0;
    alu_neg  = 1'b0;
    alu_err  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    step(); step();
    chk("rst_disp", disp_value, 0);
    chk("rst_err", err, 0);
    chk("rst_a", operand_a, 0);
    rst = 1'b0;

    // 12 + 3 = 15
    key(1); key(2); key(10); key(3); key(14);
    chk("start_pulse", calc_start, 1);
    chk("lit_a", operand_a, 12);
    chk("lit_b", operand_b, 3);
    chk("lit_op", op_sel, 0);
    step();
    chk("start_gone", calc_start, 0);
    chk("busy_wait", busy, 1);
    done(15, 0, 0);
    chk("show15", disp_value, 15);
    chk("show_busy", busy, 0);

    // digit limit
    key(15); key(1); key(2); key(3); key(4);
    chk("max_digits_a", operand_a, 123);
    chk("max_digits_disp", disp_value, 123);

    // equals in ENTER_A ignored; operator overwrite only with no B digits
    key(15); key(14); step();
    chk("eq_ignored", calc_start, 0);
    key(1); key(10); key(11);
    chk("op_overwrite", op_sel, 1);
    key(2); key(12);
    chk("op_locked", op_sel, 1);

    // timeout
    key(15); key(5); key(11); key(7); key(14);
    step();
    for (int i = 1; i < TO; i++) step();
    chk("no_err_before_timeout", err, 0);
    step();
    chk("timeout_err", err, 1);
    key(15);
    chk("clear_err", err, 0);
    chk("clear_disp", disp_value, 0);

    // divide fault
    key(9); key(13); key(0); key(14);
    done(0, 0, 1);
    chk("alu_err", err, 1);
    key(3);
    chk("err_digit_ignored", err, 1);
    chk("err_disp", disp_value, 0);
    key(15);
    chk("err_cleared", err, 0);

    // chaining
    key(4); key(12); key(1); key(0); key(14);
    done(40, 0, 0);
    chk("show40", disp_value, 40);
    key(12);
    chk("chain_a", operand_a, 40);
    chk("chain_op", op_sel, 2);
    chk("chain_disp", disp_value, 40);
    key(5); key(0); key(14);
    done(2000, 0, 0);
    key(10);
    chk("big_ignored_disp", disp_value, 2000);
    chk("big_ignored_op", op_sel, 2);

    // negative result not chainable
    key(1); key(11); key(2); key(14);
    done(1, 1, 0);
    chk("neg_disp", disp_neg, 1);
    key(10);
    chk("neg_chain_ignored", disp_neg, 1);

    // key and alu_done in the same cycle
    key(2); key(10); key(3); key(14);
    step();
    key_code = 4'd5; key_valid = 1'b1;
    alu_result = 20'd5; alu_done = 1'b1;
    step();
    key_valid = 1'b0; alu_done = 1'b0;
    chk("same_cycle_disp", disp_value, 5);
    chk("same_cycle_b", operand_b, 3);

    // reset while waiting, done arrives after
    key(1); key(10); key(1); key(14);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    alu_result = 20'd77; alu_done = 1'b1;
    step();
    alu_done = 1'b0;
    step();
    chk("rst_wait_disp", disp_value, 0);
    chk("rst_wait_busy", busy, 0);
    chk("rst_wait_a", operand_a, 0);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
